// File: rtl/priority_resolver_nested.sv
// Fully-nested PIC priority resolver: winner selection, two-pulse INTA FSM, ISR and EOI.
// Optional AUTO_EOI_EN: clear the in-service bit automatically as the 2nd INTA ends.
module priority_resolver_nested #(
    parameter int N     = 8,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     irr,
    input  logic [N-1:0]     imr,
    input  logic             rotate_mode,
    input  logic             inta_n,
    input  logic             eoi,
    input  logic             eoi_specific,
    input  logic [LVL_W-1:0] eoi_level,
    output logic             int_out,
    output logic [N-1:0]     isr,
    output logic [N-1:0]     clr_irr,
    output logic [LVL_W-1:0] vector,
    output logic             vector_valid
);

    localparam int RW = LVL_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACK1 = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_ACK2 = 2'd3;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Rank of the highest-priority set bit; N when nothing is set.
    function automatic logic [RW-1:0] find_rank(input logic [N-1:0] v,
                                                input logic [LVL_W-1:0] b);
        logic [RW-1:0] r;
        int            idx;
        r = RW'(N);
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(b) + k;
            if (idx >= N) idx = idx - N;
            if (v[idx]) r = RW'(k);
        end
        return r;
    endfunction

    function automatic logic [LVL_W-1:0] rank_to_lvl(input logic [RW-1:0] r,
                                                     input logic [LVL_W-1:0] b);
        int idx;
        idx = int'(b) + int'(r);
        if (idx >= N) idx = idx - N;
        return LVL_W'(idx);
    endfunction

    function automatic logic [LVL_W-1:0] next_base(input logic [LVL_W-1:0] lvl);
        int idx;
        idx = int'(lvl) + 1;
        if (idx >= N) idx = 0;
        return LVL_W'(idx);
    endfunction

    logic [1:0]       state_q, state_d;
    logic             inta_q;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [N-1:0]     isr_q, isr_d;
    logic [N-1:0]     clr_irr_q, clr_irr_d;
    logic             int_out_q, int_out_d;
    logic [LVL_W-1:0] vector_q, vector_d;
    logic             vv_q, vv_d;
    logic [LVL_W-1:0] base_q, base_d;

    logic [LVL_W-1:0] eff_base;
    logic [N-1:0]     req;
    logic [RW-1:0]    cand_rank, isr_rank;
    logic             win;
    logic [LVL_W-1:0] win_lvl, isr_top_lvl;
    logic             fall, rise;
    logic             clr_hit;
    logic [LVL_W-1:0] clr_lvl;
    logic [N-1:0]     clr_mask, set_mask;

    always_comb begin
        eff_base    = rotate_mode ? base_q : '0;
        req         = irr & ~imr;
        cand_rank   = find_rank(req, eff_base);
        isr_rank    = find_rank(isr_q, eff_base);
        win         = cand_rank < isr_rank;
        win_lvl     = rank_to_lvl(cand_rank, eff_base);
        isr_top_lvl = rank_to_lvl(isr_rank, eff_base);
        fall        = inta_q & ~inta_n;
        rise        = ~inta_q & inta_n;
    end

    // ISR clear source: EOI command in IDLE, or the automatic clear at end of ACK2.
    always_comb begin
        clr_hit = 1'b0;
        clr_lvl = '0;
        if (state_q == S_IDLE && eoi) begin
            if (eoi_specific) begin
                if (int'(eoi_level) < N && isr_q[eoi_level]) begin
                    clr_hit = 1'b1;
                    clr_lvl = eoi_level;
                end
            end else if (isr_rank < RW'(N)) begin
                clr_hit = 1'b1;
                clr_lvl = isr_top_lvl;
            end
        end
`ifdef AUTO_EOI_EN
        if (state_q == S_ACK2 && rise && isr_q[lvl_q]) begin
            clr_hit = 1'b1;
            clr_lvl = lvl_q;
        end
`endif
        clr_mask = clr_hit ? (ONE << clr_lvl) : '0;
    end

    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        set_mask  = '0;
        clr_irr_d = '0;
        vector_d  = vector_q;
        vv_d      = vv_q;
        int_out_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                int_out_d = win;
                if (fall) begin
                    int_out_d = 1'b0;
                    state_d   = S_ACK1;
                    if (win) begin
                        lvl_d     = win_lvl;
                        set_mask  = ONE << win_lvl;
                        clr_irr_d = ONE << win_lvl;
                    end else begin
                        // request withdrew before the acknowledge: spurious level
                        lvl_d = LVL_W'(N - 1);
                    end
                end
            end
            S_ACK1: if (rise) state_d = S_GAP;
            S_GAP: begin
                if (fall) begin
                    state_d  = S_ACK2;
                    vector_d = lvl_q;
                    vv_d     = 1'b1;
                end
            end
            default: begin
                if (rise) begin
                    state_d = S_IDLE;
                    vv_d    = 1'b0;
                end
            end
        endcase
        isr_d  = (isr_q & ~clr_mask) | set_mask;
        base_d = base_q;
        if (!rotate_mode) base_d = '0;
        else if (clr_hit) base_d = next_base(clr_lvl);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            inta_q    <= 1'b1;
            lvl_q     <= '0;
            isr_q     <= '0;
            clr_irr_q <= '0;
            int_out_q <= 1'b0;
            vector_q  <= '0;
            vv_q      <= 1'b0;
            base_q    <= '0;
        end else begin
            state_q   <= state_d;
            inta_q    <= inta_n;
            lvl_q     <= lvl_d;
            isr_q     <= isr_d;
            clr_irr_q <= clr_irr_d;
            int_out_q <= int_out_d;
            vector_q  <= vector_d;
            vv_q      <= vv_d;
            base_q    <= base_d;
        end
    end

    assign int_out      = int_out_q;
    assign isr          = isr_q;
    assign clr_irr      = clr_irr_q;
    assign vector       = vector_q;
    assign vector_valid = vv_q;

endmodule

// File: tb/tb_priority_resolver_nested.sv
// Directed bench for priority_resolver_nested: per-cycle vector table plus reset/auto-EOI sequences.
module tb_priority_resolver_nested;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irr, imr;
    logic       rotate_mode, inta_n, eoi, eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] isr, clr_irr;
    logic [2:0] vector;
    logic       vector_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    priority_resolver_nested #(.N(8), .LVL_W(3)) dut (
        .clk(clk), .reset(reset), .irr(irr), .imr(imr), .rotate_mode(rotate_mode),
        .inta_n(inta_n), .eoi(eoi), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .int_out(int_out), .isr(isr), .clr_irr(clr_irr), .vector(vector),
        .vector_valid(vector_valid)
    );

    typedef struct {
        logic [7:0] irr, imr;
        logic       rot, inta, eoi, sp;
        logic [2:0] lvl;
        logic       e_int;
        logic [7:0] e_isr, e_clr;
        logic [2:0] e_vec;
        logic       e_vv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] i_irr, input logic [7:0] i_imr, input logic i_rot,
                       input logic i_inta, input logic i_eoi, input logic i_sp,
                       input logic [2:0] i_lvl, input logic x_int, input logic [7:0] x_isr,
                       input logic [7:0] x_clr, input logic [2:0] x_vec, input logic x_vv);
        vec_t v;
        v.irr = i_irr; v.imr = i_imr; v.rot = i_rot; v.inta = i_inta;
        v.eoi = i_eoi; v.sp = i_sp; v.lvl = i_lvl;
        v.e_int = x_int; v.e_isr = x_isr; v.e_clr = x_clr; v.e_vec = x_vec; v.e_vv = x_vv;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic x_int, input logic [7:0] x_isr,
                           input logic [7:0] x_clr, input logic [2:0] x_vec, input logic x_vv);
        chk({tag, " int_out"}, 32'(int_out), 32'(x_int));
        chk({tag, " isr"}, 32'(isr), 32'(x_isr));
        chk({tag, " clr_irr"}, 32'(clr_irr), 32'(x_clr));
        chk({tag, " vector"}, 32'(vector), 32'(x_vec));
        chk({tag, " vector_valid"}, 32'(vector_valid), 32'(x_vv));
    endtask

    // One clock with the given irr/inta_n, no EOI; outputs sampled 1ns after the edge.
    task automatic cyc(input logic [7:0] i_irr, input logic i_inta);
        irr = i_irr; inta_n = i_inta; eoi = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; irr = '0; imr = '0; rotate_mode = 1'b0; inta_n = 1'b1;
        eoi = 1'b0; eoi_specific = 1'b0; eoi_level = '0;
        @(posedge clk); @(posedge clk); #1;
        chk_all("reset", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        reset = 1'b0;

        // reset in GAP aborts the sequence, then a clean acknowledge follows
        cyc(8'h10, 1'b1); chk("rg int_out", 32'(int_out), 32'd1);
        cyc(8'h10, 1'b0); chk("rg isr", 32'(isr), 32'h10); chk("rg clr", 32'(clr_irr), 32'h10);
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b1); chk("rg gap vv", 32'(vector_valid), 32'd0);
        #2 reset = 1'b1;
        #1 chk_all("rg async", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        #2 reset = 1'b0;
        cyc(8'h10, 1'b1); chk("rc int_out", 32'(int_out), 32'd1);
        cyc(8'h10, 1'b0); chk_all("rc ack1", 1'b0, 8'h10, 8'h10, 3'd0, 1'b0);
        cyc(8'h00, 1'b0); chk("rc clr", 32'(clr_irr), 32'h00);
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b0); chk_all("rc ack2", 1'b0, 8'h10, 8'h00, 3'd4, 1'b1);
        cyc(8'h00, 1'b1);
`ifdef AUTO_EOI_EN
        chk_all("rc idle", 1'b0, 8'h00, 8'h00, 3'd4, 1'b0);
`else
        chk_all("rc idle", 1'b0, 8'h10, 8'h00, 3'd4, 1'b0);
`endif

        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;

`ifndef AUTO_EOI_EN
        //   irr    imr  rot inta eoi sp lvl  int isr    clr    vec vv
        add(8'h24, 8'h00, 0, 1, 0, 0, 3'd0, 1, 8'h00, 8'h00, 3'd0, 0);
        add(8'h24, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h04, 8'h04, 3'd0, 0);
        add(8'h20, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h04, 8'h00, 3'd0, 0);
        add(8'h20, 8'h00, 0, 1, 0, 0, 3'd0, 0, 8'h04, 8'h00, 3'd0, 0);
        add(8'h20, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h04, 8'h00, 3'd2, 1);
        add(8'h20, 8'h00, 0, 1, 0, 0, 3'd0, 0, 8'h04, 8'h00, 3'd2, 0);
        add(8'h20, 8'h00, 0, 1, 0, 0, 3'd0, 0, 8'h04, 8'h00, 3'd2, 0);
        add(8'h22, 8'h00, 0, 1, 0, 0, 3'd0, 1, 8'h04, 8'h00, 3'd2, 0);
        add(8'h22, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h06, 8'h02, 3'd2, 0);
        add(8'h20, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h06, 8'h00, 3'd2, 0);
        add(8'h20, 8'h00, 0, 1, 0, 0, 3'd0, 0, 8'h06, 8'h00, 3'd2, 0);
        add(8'h20, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h06, 8'h00, 3'd1, 1);
        add(8'h20, 8'h00, 0, 1, 0, 0, 3'd0, 0, 8'h06, 8'h00, 3'd1, 0);
        add(8'h00, 8'h00, 0, 1, 1, 0, 3'd0, 0, 8'h04, 8'h00, 3'd1, 0);
        add(8'h00, 8'h00, 0, 1, 1, 1, 3'd2, 0, 8'h00, 8'h00, 3'd1, 0);
        add(8'h00, 8'h00, 0, 1, 1, 1, 3'd5, 0, 8'h00, 8'h00, 3'd1, 0);
        add(8'h00, 8'h00, 0, 1, 1, 0, 3'd0, 0, 8'h00, 8'h00, 3'd1, 0);
        // rotating mode; EOI during the sequence is dropped
        add(8'h08, 8'h00, 1, 1, 0, 0, 3'd0, 1, 8'h00, 8'h00, 3'd1, 0);
        add(8'h08, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h08, 8'h08, 3'd1, 0);
        add(8'h00, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 3'd1, 0);
        add(8'h00, 8'h00, 1, 1, 1, 0, 3'd0, 0, 8'h08, 8'h00, 3'd1, 0);
        add(8'h00, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h08, 8'h00, 3'd3, 1);
        add(8'h00, 8'h00, 1, 1, 0, 0, 3'd0, 0, 8'h08, 8'h00, 3'd3, 0);
        add(8'h00, 8'h00, 1, 1, 1, 0, 3'd0, 0, 8'h00, 8'h00, 3'd3, 0);
        add(8'h09, 8'h00, 1, 1, 0, 0, 3'd0, 1, 8'h00, 8'h00, 3'd3, 0);
        add(8'h09, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h01, 8'h01, 3'd3, 0);
        add(8'h08, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h01, 8'h00, 3'd3, 0);
        add(8'h08, 8'h00, 1, 1, 0, 0, 3'd0, 0, 8'h01, 8'h00, 3'd3, 0);
        add(8'h08, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h01, 8'h00, 3'd0, 1);
        add(8'h08, 8'h00, 1, 1, 0, 0, 3'd0, 0, 8'h01, 8'h00, 3'd0, 0);
        add(8'h20, 8'h00, 1, 1, 0, 0, 3'd0, 1, 8'h01, 8'h00, 3'd0, 0);
        add(8'h00, 8'h00, 1, 1, 1, 1, 3'd0, 0, 8'h00, 8'h00, 3'd0, 0);
        add(8'h03, 8'h00, 1, 1, 0, 0, 3'd0, 1, 8'h00, 8'h00, 3'd0, 0);
        add(8'h03, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h02, 8'h02, 3'd0, 0);
        add(8'h01, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h02, 8'h00, 3'd0, 0);
        add(8'h01, 8'h00, 1, 1, 0, 0, 3'd0, 0, 8'h02, 8'h00, 3'd0, 0);
        add(8'h01, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h02, 8'h00, 3'd1, 1);
        add(8'h00, 8'h00, 1, 1, 0, 0, 3'd0, 0, 8'h02, 8'h00, 3'd1, 0);
        // spurious acknowledge, then masking
        add(8'h00, 8'h00, 0, 1, 1, 0, 3'd0, 0, 8'h00, 8'h00, 3'd1, 0);
        add(8'h40, 8'h00, 0, 1, 0, 0, 3'd0, 1, 8'h00, 8'h00, 3'd1, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 3'd1, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 3'd1, 0);
        add(8'h00, 8'h00, 0, 1, 0, 0, 3'd0, 0, 8'h00, 8'h00, 3'd1, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 3'd7, 1);
        add(8'h00, 8'h00, 0, 1, 0, 0, 3'd0, 0, 8'h00, 8'h00, 3'd7, 0);
        add(8'h30, 8'h30, 0, 1, 0, 0, 3'd0, 0, 8'h00, 8'h00, 3'd7, 0);
        add(8'h30, 8'h10, 0, 1, 0, 0, 3'd0, 1, 8'h00, 8'h00, 3'd7, 0);
        add(8'h00, 8'h00, 0, 1, 0, 0, 3'd0, 0, 8'h00, 8'h00, 3'd7, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            irr = tbl[i].irr; imr = tbl[i].imr; rotate_mode = tbl[i].rot;
            inta_n = tbl[i].inta; eoi = tbl[i].eoi; eoi_specific = tbl[i].sp;
            eoi_level = tbl[i].lvl;
            @(posedge clk); #1;
            chk_all($sformatf("s%0d", i), tbl[i].e_int, tbl[i].e_isr, tbl[i].e_clr,
                    tbl[i].e_vec, tbl[i].e_vv);
        end
`else
        cyc(8'h80, 1'b1); chk("ae int_out", 32'(int_out), 32'd1);
        cyc(8'h80, 1'b0); chk("ae isr", 32'(isr), 32'h80); chk("ae clr", 32'(clr_irr), 32'h80);
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b0); chk_all("ae ack2", 1'b0, 8'h80, 8'h00, 3'd7, 1'b1);
        cyc(8'h00, 1'b1); chk_all("ae idle", 1'b0, 8'h00, 8'h00, 3'd7, 1'b0);
        cyc(8'h03, 1'b1);
        cyc(8'h03, 1'b0); chk("ae fixed isr", 32'(isr), 32'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
